mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data width of requester and memory ports.
REQ-002 Parameter ADDR_WIDTH, default 9: data-memory byte-address width.
REQ-003 Parameter MAX_BURST, default 8: maximum consecutive locked grants to one requester.
REQ-004 CLK  input  1  single clock; all state SHALL update on rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 reqN_valid  input  1  (N=0,1) requester N presents a transfer; N=0 is the CPU load/store port, N=1 is the loader/debug port.
REQ-007 reqN_we  input  1  1 = write, 0 = read.
REQ-008 reqN_lock  input  1  keep ownership after this transfer.
REQ-009 reqN_addr  input  ADDR_WIDTH  byte address.
REQ-010 reqN_wdata  input  DATA_WIDTH  write data.
REQ-011 reqN_ready  output  1  transfer of requester N is accepted this cycle.
REQ-012 reqN_rvalid  output  1  one-cycle response pulse.
REQ-013 reqN_rdata  output  DATA_WIDTH  read data, qualified by reqN_rvalid.
REQ-014 mem_a  output  ADDR_WIDTH, mem_wd  output  DATA_WIDTH, mem_we  output  1: data-memory command.
REQ-015 mem_rd  input  DATA_WIDTH  data-memory read data, combinational from mem_a.

Function
REQ-016 Transfer accepted when reqN_valid & reqN_ready; at most one ready SHALL be high per cycle.
REQ-017 ready SHALL be combinational from valid, lock state and priority; it SHALL NOT depend on the requester seeing ready first.
REQ-018 mem_a/mem_wd SHALL mux the granted requester's addr/wdata; with no grant they SHALL be 0.
REQ-019 mem_we SHALL equal granted reqN_we in the accept cycle, else 0.
REQ-020 Response latency is exactly 1 cycle: the cycle after accept, reqN_rvalid = 1 for reads and writes.
REQ-021 For reads, reqN_rdata SHALL hold mem_rd registered in the accept cycle; for writes it SHALL be 0. It SHALL hold its value until the next response to N.
REQ-022 FSM states: IDLE, OWN0, OWN1.
REQ-023 IDLE, one valid: grant it. Both valid: grant the requester not granted last (round robin; last_grant register).
REQ-024 IDLE -> OWNn when requester n is accepted with reqn_lock = 1; burst counter loads 1.
REQ-025 OWNn: only requester n is eligible; the other SHALL see ready = 0 even if valid.
REQ-026 OWNn, accept with lock = 0 -> IDLE.
REQ-027 OWNn, reqn_valid = 0 for one cycle -> IDLE (abandoned lock).
REQ-028 OWNn, accept when counter = MAX_BURST-1 -> IDLE regardless of lock; last_grant = n, so a waiting other requester wins next.
REQ-029 The counter increments per accept in OWNn; it SHALL never exceed MAX_BURST-1.
REQ-030 last_grant SHALL update on every accept.
REQ-031 Same-address back-to-back write then read by either requester SHALL return the written data (memory write takes effect at the accept edge).

Reset
REQ-032 RST = 1 at a rising edge: state = IDLE, last_grant = 1 (requester 0 wins first tie), counter = 0, all rvalid = 0, all rdata = 0.
REQ-033 While RST = 1: ready, mem_we, mem_a and mem_wd SHALL be 0. Any in-flight response is dropped (no rvalid after reset release).

Verification
REQ-034 Both valid reads from reset, addr0 = 0x010, addr1 = 0x020 -> cycle 1 req0_ready; cycle 2 req1_ready with req0_rvalid and rdata = mem[0x010]; cycle 3 req1_rvalid.
REQ-035 req1 write 0x0A5A5A5A @0x004, then req0 read @0x004 next cycle -> req0_rdata = 0x0A5A5A5A.
REQ-036 req1 lock = 1 for 12 transfers, req0 valid throughout, MAX_BURST = 8 -> req1 gets 8 consecutive grants, then req0 is granted once, then req1 resumes.
REQ-037 OWN0, req0 drops valid one cycle while req1 valid -> FSM returns to IDLE; req1 is granted the next cycle.
REQ-038 RST asserted in the cycle after a read accept -> no rvalid; after release state = IDLE and outputs are 0.
REQ-039 Continuous random valid/we/lock on both ports for 10k cycles -> never two readies, each accept is followed by exactly one rvalid, and no requester waits more than MAX_BURST+1 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter: round-robin between the CPU port (0) and the loader port (1),
// with lockable bursts of up to MAX_BURST grants and a registered one-cycle response.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int MAX_BURST  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic                  req0_lock,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_rvalid,
    output logic [DATA_WIDTH-1:0] req0_rdata,

    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic                  req1_lock,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_rvalid,
    output logic [DATA_WIDTH-1:0] req1_rdata,

    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    localparam int              CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam bit              CAN_LOCK = (MAX_BURST > 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t           state, state_nx;
    logic             last_grant, last_grant_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             grant0, grant1;
    logic             rvalid0_q, rvalid1_q;

    // Grant decision: a lock owner is the only eligible requester; otherwise a tie goes
    // to whoever was not granted last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!RST) begin
            case (state)
                IDLE: begin
                    if (req0_valid && req1_valid) begin
                        grant0 = last_grant;
                        grant1 = !last_grant;
                    end else begin
                        grant0 = req0_valid;
                        grant1 = req1_valid;
                    end
                end
                OWN0:    grant0 = req0_valid;
                OWN1:    grant1 = req1_valid;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        last_grant_nx = last_grant;
        if (grant0) begin
            last_grant_nx = 1'b0;
        end else if (grant1) begin
            last_grant_nx = 1'b1;
        end
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (grant0 && req0_lock && CAN_LOCK) begin
                    state_nx = OWN0;
                    cnt_nx   = CNT_W'(1);
                end else if (grant1 && req1_lock && CAN_LOCK) begin
                    state_nx = OWN1;
                    cnt_nx   = CNT_W'(1);
                end
            end
            // Leaving on a dropped valid, a released lock or an exhausted burst.
            OWN0: begin
                if (!req0_valid || !req0_lock || cnt == CNT_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            OWN1: begin
                if (!req1_valid || !req1_lock || cnt == CNT_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            req0_rdata <= '0;
            req1_rdata <= '0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            cnt        <= cnt_nx;
            rvalid0_q  <= grant0;
            rvalid1_q  <= grant1;
            if (grant0) begin
                req0_rdata <= req0_we ? '0 : mem_rd;
            end
            if (grant1) begin
                req1_rdata <= req1_we ? '0 : mem_rd;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // A response still pending when reset arrives must never become visible.
    assign req0_rvalid = rvalid0_q & ~RST;
    assign req1_rvalid = rvalid1_q & ~RST;

    assign mem_a  = grant0 ? req0_addr  : (grant1 ? req1_addr  : '0);
    assign mem_wd = grant0 ? req0_wdata : (grant1 ? req1_wdata : '0);
    assign mem_we = (grant0 & req0_we) | (grant1 & req1_we);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed arbitration vectors with hand-computed grants and data,
// a response scoreboard drained by an independent monitor, then a randomized invariant phase.
module tb_mem_arbiter;

    localparam int MAX_BURST = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req0_valid, req0_we, req0_lock;
    logic [8:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic        req0_ready, req0_rvalid;
    logic [31:0] req0_rdata;
    logic        req1_valid, req1_we, req1_lock;
    logic [8:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic        req1_ready, req1_rvalid;
    logic [31:0] req1_rdata;
    logic [8:0]  mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    resp_t       rq0[$];
    resp_t       rq1[$];
    resp_t       mon_r0, mon_r1;
    logic [31:0] mem    [0:127];
    logic [31:0] shadow [0:127];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          wait0 = 0;
    int          wait1 = 0;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .MAX_BURST(MAX_BURST)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i]    = init_word(i);
            shadow[i] = init_word(i);
        end
    end

    // Word-addressed data memory: combinational read, write at the accept edge.
    assign mem_rd = mem[mem_a[8:2]];
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (mem_we) mem[mem_a[8:2]] <= mem_wd;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every response due this cycle must appear with the queued data; otherwise rvalid stays low.
    always @(negedge CLK) begin
        if (rq0.size() > 0 && rq0[0].due <= cyc) begin
            mon_r0 = rq0.pop_front();
            checkOutput("req0_rvalid", 32'(req0_rvalid), 32'd1);
            if (req0_rvalid) checkOutput("req0_rdata", req0_rdata, mon_r0.data);
        end else begin
            checkOutput("req0_rvalid idle", 32'(req0_rvalid), 32'd0);
        end
        if (rq1.size() > 0 && rq1[0].due <= cyc) begin
            mon_r1 = rq1.pop_front();
            checkOutput("req1_rvalid", 32'(req1_rvalid), 32'd1);
            if (req1_rvalid) checkOutput("req1_rdata", req1_rdata, mon_r1.data);
        end else begin
            checkOutput("req1_rvalid idle", 32'(req1_rvalid), 32'd0);
        end
    end

    task automatic setReq0(input logic v, input logic we, input logic lk, input logic [8:0] a, input logic [31:0] wd);
        req0_valid = v; req0_we = we; req0_lock = lk; req0_addr = a; req0_wdata = wd;
    endtask

    task automatic setReq1(input logic v, input logic we, input logic lk, input logic [8:0] a, input logic [31:0] wd);
        req1_valid = v; req1_we = we; req1_lock = lk; req1_addr = a; req1_wdata = wd;
    endtask

    // One cycle with hand-computed grants; queues the expected response of the granted port.
    task automatic applyStimulus(input logic exp0, input logic exp1, input logic [31:0] exp_d0, input logic [31:0] exp_d1);
        logic [8:0]  exp_a;
        logic [31:0] exp_wd;
        logic        exp_we;
        #1;
        checkOutput("req0_ready", 32'(req0_ready), 32'(exp0));
        checkOutput("req1_ready", 32'(req1_ready), 32'(exp1));
        exp_a  = exp0 ? req0_addr  : (exp1 ? req1_addr  : 9'd0);
        exp_wd = exp0 ? req0_wdata : (exp1 ? req1_wdata : 32'd0);
        exp_we = (exp0 & req0_we) | (exp1 & req1_we);
        checkOutput("mem_a", 32'(mem_a), 32'(exp_a));
        checkOutput("mem_wd", mem_wd, exp_wd);
        checkOutput("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp0) begin
            rq0.push_back('{cyc + 1, exp_d0});
            if (req0_we) shadow[req0_addr[8:2]] = req0_wdata;
        end
        if (exp1) begin
            rq1.push_back('{cyc + 1, exp_d1});
            if (req1_we) shadow[req1_addr[8:2]] = req1_wdata;
        end
        @(posedge CLK);
        #1;
    endtask

    // Random cycle: checks exclusivity, mux and fairness; expected data comes from the shadow memory.
    task automatic randomCycle();
        setReq0(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                9'($urandom_range(0, 7)) << 2, $urandom());
        setReq1(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                9'($urandom_range(0, 7)) << 2, $urandom());
        #1;
        checkOutput("ready exclusive", 32'(req0_ready & req1_ready), 32'd0);
        checkOutput("ready0 without valid", 32'(req0_ready & ~req0_valid), 32'd0);
        checkOutput("ready1 without valid", 32'(req1_ready & ~req1_valid), 32'd0);
        if (req0_ready) begin
            checkOutput("rand mem_a0", 32'(mem_a), 32'(req0_addr));
            checkOutput("rand mem_we0", 32'(mem_we), 32'(req0_we));
            rq0.push_back('{cyc + 1, req0_we ? 32'd0 : shadow[req0_addr[8:2]]});
            if (req0_we) shadow[req0_addr[8:2]] = req0_wdata;
        end
        if (req1_ready) begin
            checkOutput("rand mem_a1", 32'(mem_a), 32'(req1_addr));
            checkOutput("rand mem_we1", 32'(mem_we), 32'(req1_we));
            rq1.push_back('{cyc + 1, req1_we ? 32'd0 : shadow[req1_addr[8:2]]});
            if (req1_we) shadow[req1_addr[8:2]] = req1_wdata;
        end
        wait0 = (req0_valid && !req0_ready) ? wait0 + 1 : 0;
        wait1 = (req1_valid && !req1_ready) ? wait1 + 1 : 0;
        checkOutput("wait0 bound", 32'(wait0 > MAX_BURST + 1), 32'd0);
        checkOutput("wait1 bound", 32'(wait1 > MAX_BURST + 1), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        setReq0(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        setReq1(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // Reset holds off grants and memory command even with both ports requesting writes.
        setReq0(1'b1, 1'b1, 1'b0, 9'h004, 32'h1111_1111);
        setReq1(1'b1, 1'b1, 1'b0, 9'h008, 32'h2222_2222);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        setReq0(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        setReq1(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        RST = 1'b0;
        checkOutput("reset rdata0", req0_rdata, 32'd0);
        checkOutput("reset rdata1", req1_rdata, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        // Tie from reset: port 0 first, then port 1, then port 0 again.
        setReq0(1'b1, 1'b0, 1'b0, 9'h010, 32'd0);
        setReq1(1'b1, 1'b0, 1'b0, 9'h020, 32'd0);
        applyStimulus(1'b1, 1'b0, init_word(4), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'd0, init_word(8));
        setReq1(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        applyStimulus(1'b1, 1'b0, init_word(4), 32'd0);
        setReq0(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        // Write followed immediately by a read of the same word, from each port.
        setReq1(1'b1, 1'b1, 1'b0, 9'h004, 32'h0A5A_5A5A);
        applyStimulus(1'b0, 1'b1, 32'd0, 32'd0);
        setReq1(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        setReq0(1'b1, 1'b0, 1'b0, 9'h004, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0A5A_5A5A, 32'd0);
        setReq0(1'b1, 1'b1, 1'b0, 9'h00C, 32'h3C3C_0001);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0);
        setReq0(1'b1, 1'b0, 1'b0, 9'h00C, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h3C3C_0001, 32'd0);

        // Locked burst on port 1: 8 grants, one for port 0, 4 more, then an abandoned lock.
        setReq0(1'b1, 1'b0, 1'b0, 9'h044, 32'd0);
        setReq1(1'b1, 1'b0, 1'b1, 9'h040, 32'd0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 32'd0, init_word(16));
        applyStimulus(1'b1, 1'b0, init_word(17), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 32'd0, init_word(16));
        setReq1(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b1, 1'b0, init_word(17), 32'd0);

        // Port 0 owns, port 1 is blocked, port 0 drops valid, port 1 wins the following tie.
        setReq0(1'b1, 1'b0, 1'b1, 9'h044, 32'd0);
        applyStimulus(1'b1, 1'b0, init_word(17), 32'd0);
        setReq1(1'b1, 1'b0, 1'b0, 9'h020, 32'd0);
        applyStimulus(1'b1, 1'b0, init_word(17), 32'd0);
        setReq0(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        setReq0(1'b1, 1'b0, 1'b0, 9'h044, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'd0, init_word(8));
        setReq0(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        setReq1(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        // Reset in the cycle after a read accept swallows the response.
        setReq0(1'b1, 1'b0, 1'b0, 9'h010, 32'd0);
        applyStimulus(1'b1, 1'b0, init_word(4), 32'd0);
        RST = 1'b1;
        rq0.delete();
        setReq0(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        RST = 1'b0;
        checkOutput("post-reset rdata0", req0_rdata, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        setReq0(1'b1, 1'b0, 1'b0, 9'h020, 32'd0);
        setReq1(1'b1, 1'b0, 1'b0, 9'h010, 32'd0);
        applyStimulus(1'b1, 1'b0, init_word(8), 32'd0);
        setReq0(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        setReq1(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        $display("[TB] directed vectors done, starting random traffic");
        wait0 = 0;
        wait1 = 0;
        for (int i = 0; i < 10000; i++) randomCycle();

        setReq0(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        setReq1(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        repeat (3) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("queue0 drained", 32'(rq0.size()), 32'd0);
        checkOutput("queue1 drained", 32'(rq1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
